// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / branch hazard stall, flush and halt.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
module id_ex_hazard_stage #(
  parameter int RA_IDX      = 31,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST_n,
  input  logic [1:0]             iRegDst,
  input  logic [1:0]             iOrigALU,
  input  logic [1:0]             iMemparaReg,
  input  logic                   iEscreveReg,
  input  logic                   iLeMem,
  input  logic                   iEscreveMem,
  input  logic [1:0]             iOpALU,
  input  logic [2:0]             iOrigPC,
  input  logic                   iJump,
  input  logic                   iBranch,
  input  logic                   inBranch,
  input  logic                   iJr,
  input  logic [4:0]             iRs,
  input  logic [4:0]             iRt,
  input  logic [4:0]             iRd,
  input  logic                   iBranchTaken,
  input  logic                   iMEM_LeMem,
  input  logic [4:0]             iMEM_Dest,
  output logic [1:0]             oRegDst_EX,
  output logic [1:0]             oOrigALU_EX,
  output logic [1:0]             oMemparaReg_EX,
  output logic [1:0]             oOpALU_EX,
  output logic                   oEscreveReg_EX,
  output logic                   oLeMem_EX,
  output logic                   oEscreveMem_EX,
  output logic                   oJr_EX,
  output logic [4:0]             oDest_EX,
  output logic                   oPCWrite,
  output logic                   oIFIDWrite,
  output logic                   oIFIDFlush,
  output logic                   oHalt,
`ifdef HAZARD_STATS_EN
  output logic [STALL_CNT_W-1:0] oStallCnt,
  output logic [STALL_CNT_W-1:0] oFlushCnt,
`endif
  output logic [1:0]             oState
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] regdst;
    logic [1:0] origalu;
    logic [1:0] mempara;
    logic [1:0] opalu;
    logic       wr;
    logic       ld;
    logic       st;
    logic       jr;
    logic [4:0] dest;
  } ctl_t;

  state_e state_q, state_d;
  ctl_t   ctl_q, ctl_d, word;
  logic   uses_rt, ex_hit, mem_hit, stall, redirect;
  logic   pc_wr, flush, halt;

  // Resolve destination register and assemble the decoder word
  always_comb begin
    word         = '0;
    word.regdst  = iRegDst;
    word.origalu = iOrigALU;
    word.mempara = iMemparaReg;
    word.opalu   = iOpALU;
    word.wr      = iEscreveReg;
    word.ld      = iLeMem;
    word.st      = iEscreveMem;
    word.jr      = iJr;
    case (iRegDst)
      2'b00:   word.dest = iRt;
      2'b01:   word.dest = iRd;
      2'b10:   word.dest = 5'(RA_IDX);
      default: word.dest = 5'd0;
    endcase
  end

  // Hazard detection against EX and MEM producers ($0 is immune)
  always_comb begin
    uses_rt = (iOrigALU == 2'b00) | iEscreveMem
            | iBranch | inBranch;
    ex_hit  = ctl_q.wr && (ctl_q.dest != 5'd0)
            && ((ctl_q.dest == iRs)
             || (uses_rt && (ctl_q.dest == iRt)));
    mem_hit = iMEM_LeMem && (iMEM_Dest != 5'd0)
            && ((iMEM_Dest == iRs)
             || (uses_rt && (iMEM_Dest == iRt)));
    stall   = (ctl_q.ld && ex_hit)
            || ((iBranch | inBranch | iJr)
                && (ex_hit || mem_hit));
    redirect = iJump | (iBranch & iBranchTaken)
             | (inBranch & iBranchTaken);
  end

  // Next-state and pipeline control decisions
  always_comb begin
    state_d = state_q;
    ctl_d   = '0;
    pc_wr   = 1'b0;
    flush   = 1'b0;
    halt    = 1'b0;
    case (state_q)
      S_HALT: begin
        halt    = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        if (stall) begin
          state_d = S_STALL;
        end else begin
          pc_wr = 1'b1;
          flush = redirect;
          if (iOrigPC == 3'b111) begin
            state_d = S_HALT;
          end else begin
            state_d = S_RUN;
            ctl_d   = word;
          end
        end
      end
    endcase
  end

  // State and ID/EX register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_RUN;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign oPCWrite       = iRST_n & pc_wr;
  assign oIFIDWrite     = iRST_n & pc_wr;
  assign oIFIDFlush     = iRST_n & flush;
  assign oHalt          = iRST_n & halt;
  assign oState         = state_q;
  assign oRegDst_EX     = ctl_q.regdst;
  assign oOrigALU_EX    = ctl_q.origalu;
  assign oMemparaReg_EX = ctl_q.mempara;
  assign oOpALU_EX      = ctl_q.opalu;
  assign oEscreveReg_EX = ctl_q.wr;
  assign oLeMem_EX      = ctl_q.ld;
  assign oEscreveMem_EX = ctl_q.st;
  assign oJr_EX         = ctl_q.jr;
  assign oDest_EX       = ctl_q.dest;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STALL_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, frozen while halted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != S_HALT) && stall && (~&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (~&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign oStallCnt = stall_cnt_q;
  assign oFlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed hazard scenarios plus
// randomized traffic checked against a behavioural model.
module tb_id_ex_hazard_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] i_regdst, i_origalu, i_mempara, i_opalu;
  logic       i_wr, i_ld, i_st, i_jump, i_br, i_nbr, i_jr;
  logic [2:0] i_origpc;
  logic [4:0] i_rs, i_rt, i_rd, i_mem_dest;
  logic       i_taken, i_mem_ld;

  logic [1:0] o_regdst, o_origalu, o_mempara, o_opalu, o_state;
  logic       o_wr, o_ld, o_st, o_jr;
  logic [4:0] o_dest;
  logic       o_pcw, o_ifw, o_flush, o_halt;
`ifdef HAZARD_STATS_EN
  logic [15:0] o_scnt, o_fcnt;
`endif

  id_ex_hazard_stage dut (
    .iCLK(clk), .iRST_n(rst_n),
    .iRegDst(i_regdst), .iOrigALU(i_origalu),
    .iMemparaReg(i_mempara), .iEscreveReg(i_wr),
    .iLeMem(i_ld), .iEscreveMem(i_st),
    .iOpALU(i_opalu), .iOrigPC(i_origpc),
    .iJump(i_jump), .iBranch(i_br), .inBranch(i_nbr),
    .iJr(i_jr), .iRs(i_rs), .iRt(i_rt), .iRd(i_rd),
    .iBranchTaken(i_taken), .iMEM_LeMem(i_mem_ld),
    .iMEM_Dest(i_mem_dest),
    .oRegDst_EX(o_regdst), .oOrigALU_EX(o_origalu),
    .oMemparaReg_EX(o_mempara), .oOpALU_EX(o_opalu),
    .oEscreveReg_EX(o_wr), .oLeMem_EX(o_ld),
    .oEscreveMem_EX(o_st), .oJr_EX(o_jr),
    .oDest_EX(o_dest), .oPCWrite(o_pcw),
    .oIFIDWrite(o_ifw), .oIFIDFlush(o_flush),
    .oHalt(o_halt),
`ifdef HAZARD_STATS_EN
    .oStallCnt(o_scnt), .oFlushCnt(o_fcnt),
`endif
    .oState(o_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, a, e, $time);
    end
  endtask

  typedef struct {
    logic [1:0] regdst, origalu, mempara, opalu;
    logic       wr, ld, st, jr;
    logic [4:0] dest;
  } ex_t;

  function automatic ex_t bubble();
    ex_t b;
    b = '{default: '0};
    return b;
  endfunction

  localparam int CMAX = 65535;
  ex_t m_ex = '{default: '0};
  ex_t n_ex = '{default: '0};
  int  m_st = 0, n_st = 0;
  int  m_sc = 0, m_fc = 0, n_sc = 0, n_fc = 0;
  bit  pend = 0;

  // Compare process: outputs vs. model every cycle
  always @(negedge clk) begin : cmp
    ex_t w;
    bit ut, exh, memh, stl, redir, e_pcw, e_fl;
    if (!rst_n) begin
      m_ex = bubble(); m_st = 0; m_sc = 0; m_fc = 0;
      pend = 0;
    end
    chk("ex_regdst", 32'(o_regdst), 32'(m_ex.regdst));
    chk("ex_origalu", 32'(o_origalu), 32'(m_ex.origalu));
    chk("ex_mempara", 32'(o_mempara), 32'(m_ex.mempara));
    chk("ex_opalu", 32'(o_opalu), 32'(m_ex.opalu));
    chk("ex_wr", 32'(o_wr), 32'(m_ex.wr));
    chk("ex_ld", 32'(o_ld), 32'(m_ex.ld));
    chk("ex_st", 32'(o_st), 32'(m_ex.st));
    chk("ex_jr", 32'(o_jr), 32'(m_ex.jr));
    chk("ex_dest", 32'(o_dest), 32'(m_ex.dest));
    chk("state", 32'(o_state), 32'(m_st));
    chk("halt", 32'(o_halt), 32'(m_st == 2));
`ifdef HAZARD_STATS_EN
    chk("stallcnt", 32'(o_scnt), 32'(m_sc));
    chk("flushcnt", 32'(o_fcnt), 32'(m_fc));
`endif
    if (!rst_n) begin
      chk("rst_pcw", 32'(o_pcw), 0);
      chk("rst_ifw", 32'(o_ifw), 0);
      chk("rst_flush", 32'(o_flush), 0);
    end else begin
      w.regdst = i_regdst; w.origalu = i_origalu;
      w.mempara = i_mempara; w.opalu = i_opalu;
      w.wr = i_wr; w.ld = i_ld; w.st = i_st; w.jr = i_jr;
      case (i_regdst)
        2'd0: w.dest = i_rt;
        2'd1: w.dest = i_rd;
        2'd2: w.dest = 5'd31;
        default: w.dest = 5'd0;
      endcase
      ut = (i_origalu == 0) || i_st || i_br || i_nbr;
      exh = m_ex.wr && m_ex.dest != 0 &&
            (m_ex.dest == i_rs || (ut && m_ex.dest == i_rt));
      memh = i_mem_ld && i_mem_dest != 0 &&
             (i_mem_dest == i_rs || (ut && i_mem_dest == i_rt));
      stl = (m_ex.ld && exh) ||
            ((i_br || i_nbr || i_jr) && (exh || memh));
      redir = i_jump || (i_taken && (i_br || i_nbr));
      n_ex = bubble(); n_sc = m_sc; n_fc = m_fc;
      if (m_st == 2) begin
        e_pcw = 0; e_fl = 0; n_st = 2;
      end else if (stl) begin
        e_pcw = 0; e_fl = 0; n_st = 1;
        n_sc = (m_sc < CMAX) ? m_sc + 1 : m_sc;
      end else begin
        e_pcw = 1; e_fl = redir;
        if (redir) n_fc = (m_fc < CMAX) ? m_fc + 1 : m_fc;
        if (i_origpc == 3'b111) n_st = 2;
        else begin n_st = 0; n_ex = w; end
      end
      chk("pcwrite", 32'(o_pcw), 32'(e_pcw));
      chk("ifidwrite", 32'(o_ifw), 32'(e_pcw));
      chk("flush", 32'(o_flush), 32'(e_fl));
      pend = 1;
    end
  end

  // Model register update on the active edge
  always @(posedge clk) begin
    if (rst_n && pend) begin
      m_ex = n_ex; m_st = n_st; m_sc = n_sc; m_fc = n_fc;
    end
  end

  task automatic set_nop();
    i_regdst = 0; i_origalu = 0; i_mempara = 0; i_opalu = 0;
    i_wr = 0; i_ld = 0; i_st = 0; i_jump = 0; i_br = 0;
    i_nbr = 0; i_jr = 0; i_origpc = 0; i_rs = 0; i_rt = 0;
    i_rd = 0; i_taken = 0; i_mem_ld = 0; i_mem_dest = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    i_origalu = 2'b01; i_mempara = 2'b01; i_wr = 1; i_ld = 1;
    i_rs = rs; i_rt = rt;
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
    set_nop();
    i_regdst = 2'b01; i_wr = 1; i_opalu = 2'b10;
    i_rs = rs; i_rt = rt; i_rd = rd;
  endtask

  task automatic set_beq(input logic [4:0] rs, input logic [4:0] rt,
                         input logic tk);
    set_nop();
    i_br = 1; i_opalu = 2'b01; i_origpc = 3'b001;
    i_rs = rs; i_rt = rt; i_taken = tk;
  endtask

  task automatic rnd_inputs();
    i_regdst = 2'($urandom_range(0, 3));
    i_origalu = 2'($urandom_range(0, 3));
    i_mempara = 2'($urandom_range(0, 3));
    i_opalu = 2'($urandom_range(0, 3));
    i_wr = 1'($urandom_range(0, 1));
    i_ld = 1'($urandom_range(0, 1));
    i_st = 1'($urandom_range(0, 1));
    i_jump = ($urandom_range(0, 5) == 0);
    i_br = ($urandom_range(0, 3) == 0);
    i_nbr = ($urandom_range(0, 3) == 0);
    i_jr = ($urandom_range(0, 5) == 0);
    i_origpc = ($urandom_range(0, 149) == 0) ? 3'b111
             : 3'($urandom_range(0, 6));
    i_rs = 5'($urandom_range(0, 3));
    i_rt = 5'($urandom_range(0, 3));
    i_rd = 5'($urandom_range(0, 3));
    i_taken = 1'($urandom_range(0, 1));
    i_mem_ld = 1'($urandom_range(0, 1));
    i_mem_dest = 5'($urandom_range(0, 3));
  endtask

  initial begin
    int hcnt;
    // Reset with nonzero decoder inputs
    set_add(5'd3, 5'd4, 5'd5);
    i_jump = 1;
    mid();
    chk("rst_pcw_lit", 32'(o_pcw), 0);
    chk("rst_state_lit", 32'(o_state), 0);
    chk("rst_wr_lit", 32'(o_wr), 0);
    chk("rst_dest_lit", 32'(o_dest), 0);
    tick();
    rst_n = 1;
    set_nop();
    mid();
    chk("rel_pcw_lit", 32'(o_pcw), 1);

    // Load-use: lw $8 then add rs=8
    tick(); set_lw(5'd1, 5'd8);
    tick(); set_add(5'd8, 5'd2, 5'd10);
    mid(); chk("lu_pcw_lit", 32'(o_pcw), 0);
    tick();
    chk("lu_state_lit", 32'(o_state), 1);
    chk("lu_bubble_lit", 32'(o_ld), 0);
    mid(); chk("lu_pcw2_lit", 32'(o_pcw), 1);
    tick();
    chk("lu_dest_lit", 32'(o_dest), 10);
    chk("lu_state2_lit", 32'(o_state), 0);

    // $0 immunity
    set_lw(5'd1, 5'd0);
    tick(); set_add(5'd0, 5'd0, 5'd11);
    mid(); chk("r0_pcw_lit", 32'(o_pcw), 1);

    // add $9 then beq rs=9: one stall
    tick(); set_add(5'd1, 5'd2, 5'd9);
    tick(); set_beq(5'd9, 5'd3, 1'b0);
    mid(); chk("bex_pcw_lit", 32'(o_pcw), 0);
    tick(); chk("bex_state_lit", 32'(o_state), 1);
    mid(); chk("bex_pcw2_lit", 32'(o_pcw), 1);

    // lw $9 then beq rs=9: two stalls, then taken -> flush
    tick(); set_lw(5'd1, 5'd9);
    tick(); set_beq(5'd9, 5'd3, 1'b0);
    mid(); chk("blw_pcw1_lit", 32'(o_pcw), 0);
    tick(); i_mem_ld = 1; i_mem_dest = 5'd9;
    mid(); chk("blw_pcw2_lit", 32'(o_pcw), 0);
    chk("blw_fl2_lit", 32'(o_flush), 0);
    tick(); set_beq(5'd9, 5'd3, 1'b1);
    mid(); chk("blw_pcw3_lit", 32'(o_pcw), 1);
    chk("blw_fl3_lit", 32'(o_flush), 1);
    tick(); set_nop();
    mid(); chk("blw_fl4_lit", 32'(o_flush), 0);

    // jal
    tick(); set_nop();
    i_regdst = 2'b10; i_jump = 1; i_wr = 1;
    i_mempara = 2'b10; i_origpc = 3'b010;
    mid();
    chk("jal_fl_lit", 32'(o_flush), 1);
    chk("jal_pcw_lit", 32'(o_pcw), 1);
    tick(); set_nop();
    chk("jal_dest_lit", 32'(o_dest), 31);

    // Halt, with a would-be stall present during halt
    i_origpc = 3'b111;
    tick(); set_beq(5'd5, 5'd6, 1'b1);
    i_mem_ld = 1; i_mem_dest = 5'd5;
    chk("halt_state_lit", 32'(o_state), 2);
    chk("halt_halt_lit", 32'(o_halt), 1);
    repeat (4) begin
      mid(); chk("halt_pcw_lit", 32'(o_pcw), 0);
      tick();
    end
    chk("halt_state2_lit", 32'(o_state), 2);
`ifdef HAZARD_STATS_EN
    chk("scnt_lit", 32'(o_scnt), 4);
    chk("fcnt_lit", 32'(o_fcnt), 2);
`endif
    #2 rst_n = 0;
    #1;
    chk("async_state_lit", 32'(o_state), 0);
    chk("async_halt_lit", 32'(o_halt), 0);
    tick(); rst_n = 1; set_nop();
    mid(); chk("post_pcw_lit", 32'(o_pcw), 1);

    // Randomized traffic
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rnd_inputs();
      if (m_st == 2) hcnt++;
      if (hcnt > 3) begin
        rst_n = 0; hcnt = 0;
        tick();
        rst_n = 1;
      end
    end
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- Sits directly downstream of the instruction-decode control decoder.
- Registers that decoder's control word, plus the resolved destination register, into the ID/EX pipeline register.
- Detects load-use and branch-in-ID data hazards and stalls PC and IF/ID when they occur.
- Inserts bubbles, flushes IF/ID on taken redirects, and halts the pipeline on an unrecognised instruction (OrigPC = 3'b111).

Parameters:
- RA_IDX, 31, register index written when RegDst = 2'b10.
- STALL_CNT_W, 16, width of the optional statistics counters.

Ports:
- iCLK  in  1  pipeline clock
- iRST_n  in  1  asynchronous active-low reset
- iRegDst  in  2  decoder RegDst (00 rt, 01 rd, 10 RA_IDX)
- iOrigALU  in  2  decoder ALU B-source select
- iMemparaReg  in  2  decoder writeback select
- iEscreveReg  in  1  decoder register-write enable
- iLeMem  in  1  decoder memory read
- iEscreveMem  in  1  decoder memory write
- iOpALU  in  2  decoder ALU op class
- iOrigPC  in  3  decoder PC source
- iJump  in  1  decoder jump
- iBranch  in  1  decoder beq
- inBranch  in  1  decoder bne
- iJr  in  1  decoder jr
- iRs  in  5  rs field of the ID instruction
- iRt  in  5  rt field of the ID instruction
- iRd  in  5  rd field of the ID instruction
- iBranchTaken  in  1  branch comparison result resolved in ID
- iMEM_LeMem  in  1  EX/MEM stage is a load
- iMEM_Dest  in  5  EX/MEM destination register
- oRegDst_EX, oOrigALU_EX, oMemparaReg_EX, oOpALU_EX  out  2 each  registered controls
- oEscreveReg_EX, oLeMem_EX, oEscreveMem_EX, oJr_EX  out  1 each  registered controls
- oDest_EX  out  5  registered resolved destination register
- oPCWrite  out  1  PC load enable
- oIFIDWrite  out  1  IF/ID load enable
- oIFIDFlush  out  1  clear IF/ID on the next edge
- oHalt  out  1  pipeline halted
- oState  out  2  00 RUN, 01 STALL, 10 HALT
- oStallCnt, oFlushCnt  out  STALL_CNT_W  only present with the optional feature

Behaviour:
- Reset (iRST_n low, asynchronous):
  - all *_EX outputs are 0; state is RUN.
  - oPCWrite, oIFIDWrite, oIFIDFlush and oHalt are 0 while reset is held.
- Destination resolution (combinational): dest = iRt for RegDst 00, iRd for 01, RA_IDX for 10; 11 resolves to 0.
- usesRt = (iOrigALU == 00) | iEscreveMem | iBranch | inBranch.
- Load-use hazard:
  - condition: oLeMem_EX & oEscreveReg_EX & oDest_EX != 0 & (oDest_EX == iRs | (usesRt & oDest_EX == iRt)).
- Branch hazard (only when iBranch | inBranch | iJr):
  - EX side: oEscreveReg_EX & oDest_EX != 0 matching iRs, or matching iRt when usesRt.
  - MEM side: iMEM_LeMem & iMEM_Dest != 0 matching iRs, or matching iRt when usesRt.
- stall = load-use hazard | branch hazard.
- Register $0 never causes a hazard.
- States:
  - RUN/STALL: stall = 1 → next state STALL, oPCWrite = 0, oIFIDWrite = 0, ID/EX loads a bubble (all controls 0, dest 0), oIFIDFlush = 0.
  - RUN/STALL: stall = 0 → next state RUN, oPCWrite = 1, oIFIDWrite = 1, ID/EX loads the decoder word and dest.
  - RUN/STALL: stall = 0 & (iOrigPC == 111) → next state HALT; ID/EX loads a bubble.
  - HALT: oPCWrite = 0, oIFIDWrite = 0, oHalt = 1, bubbles every cycle, oIFIDFlush = 0. Only reset exits HALT.
- Flush:
  - oIFIDFlush = 1 for exactly the cycle where stall = 0 and any of: iJump, (iBranch & iBranchTaken), (inBranch & iBranchTaken).
  - The redirecting instruction itself still enters ID/EX.
  - Stall has priority: a hazarded branch never flushes until its hazard clears.
- Latency: one cycle from decoder inputs to *_EX outputs.
- Stalls hold for consecutive cycles with no limit.
- oState is a registered output.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - oStallCnt increments on every stall cycle; oFlushCnt increments on every flush cycle.
  - Both saturate at all-ones and reset to 0.
  - Neither counts while in HALT.
- Undefined: the ports and counters are absent; other behaviour is identical.

Test Plan:
- Reset: hold iRST_n = 0 with nonzero inputs → all *_EX = 0, oState = 00, oPCWrite = 0; release → oPCWrite = 1 next cycle.
- Load-use: lw to $8 (dest 8) then add with rs = 8 → one stall cycle (oPCWrite = 0, bubble in EX, oState = 01), then add enters EX with oDest_EX = rd.
- $0 immunity: lw to $0 then add with rs = 0 → no stall.
- Branch hazards:
  - add writing $9 then beq with rs = 9 → 1 stall cycle.
  - lw writing $9 then beq with rs = 9 → 2 stall cycles (EX then MEM).
  - Then iBranchTaken = 1 → oIFIDFlush = 1 for exactly 1 cycle.
- jal: iRegDst = 10, iJump = 1 → oDest_EX = 31, oIFIDFlush = 1, no stall.
- Halt: iOrigPC = 111 → oState = 10, oHalt = 1, oPCWrite = 0 indefinitely; an async reset mid-halt returns to RUN. With HAZARD_STATS_EN, oStallCnt is frozen during halt.
